// File: rtl/spart_pkg.sv
// Shared SPART definitions: receiver state encoding and framing constants.
package spart_pkg;
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} rx_state_t;

  localparam int SPART_OVERSAMPLE = 16;
  localparam int SPART_DATA_BITS  = 8;
endpackage

// File: rtl/sync2.sv
// Two-flop synchronizer for an asynchronous single-bit input; reset value is parameterized.
module sync2 #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o
);
  logic meta_q, sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;
endmodule

// File: rtl/receive.sv
// 8N1 UART receiver with oversampled bit timing and a one-byte holding register.
// Optional framing-error output enabled by defining RECEIVE_FERR_EN.
module receive
  import spart_pkg::*;
#(
  parameter int OVERSAMPLE = SPART_OVERSAMPLE
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       receive_baud,
  input  logic                       rxd,
  input  logic                       receive_read_en,
  output logic [SPART_DATA_BITS-1:0] receive_read_line,
`ifdef RECEIVE_FERR_EN
  output logic                       ferr,
`endif
  output logic                       rda
);
  localparam int SW = $clog2(OVERSAMPLE);
  localparam logic [SW-1:0] HALF_M1 = SW'(OVERSAMPLE / 2 - 1);
  localparam logic [SW-1:0] LAST    = SW'(OVERSAMPLE - 1);
  localparam logic [3:0]    LAST_BIT = 4'(SPART_DATA_BITS - 1);

  logic                       rxd_s;
  rx_state_t                  state_q;
  logic [SW-1:0]              smp_cnt_q;
  logic [3:0]                 bit_cnt_q;
  logic [SPART_DATA_BITS-1:0] shift_q;
  logic [SPART_DATA_BITS-1:0] data_q;
  logic                       rda_q;
`ifdef RECEIVE_FERR_EN
  logic                       ferr_q;
`endif

  sync2 #(.RST_VAL(1'b1)) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d_i   (rxd),
    .q_o   (rxd_s)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      smp_cnt_q <= '0;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      data_q    <= '0;
      rda_q     <= 1'b0;
`ifdef RECEIVE_FERR_EN
      ferr_q    <= 1'b0;
`endif
    end else begin
      // Read clears first so that a completing frame below overrides it.
      if (receive_read_en) begin
        rda_q <= 1'b0;
`ifdef RECEIVE_FERR_EN
        ferr_q <= 1'b0;
`endif
      end
      case (state_q)
        IDLE: begin
          if (!rxd_s) begin
            state_q   <= START;
            smp_cnt_q <= '0;
          end
        end
        START: begin
          if (receive_baud) begin
            if (smp_cnt_q == HALF_M1) begin
              if (!rxd_s) begin
                state_q   <= DATA;
                smp_cnt_q <= '0;
                bit_cnt_q <= '0;
              end else begin
                state_q <= IDLE;
              end
            end else begin
              smp_cnt_q <= smp_cnt_q + 1'b1;
            end
          end
        end
        DATA: begin
          if (receive_baud) begin
            if (smp_cnt_q == LAST) begin
              shift_q   <= {rxd_s, shift_q[SPART_DATA_BITS-1:1]};
              bit_cnt_q <= bit_cnt_q + 1'b1;
              smp_cnt_q <= '0;
              if (bit_cnt_q == LAST_BIT) state_q <= STOP;
            end else begin
              smp_cnt_q <= smp_cnt_q + 1'b1;
            end
          end
        end
        STOP: begin
          if (receive_baud) begin
            if (smp_cnt_q == LAST) begin
              data_q    <= shift_q;
              rda_q     <= 1'b1;
`ifdef RECEIVE_FERR_EN
              ferr_q    <= ~rxd_s;
`endif
              smp_cnt_q <= '0;
              // Re-arm mid stop bit so a slightly early next start edge is caught.
              state_q   <= IDLE;
            end else begin
              smp_cnt_q <= smp_cnt_q + 1'b1;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign receive_read_line = data_q;
  assign rda               = rda_q;
`ifdef RECEIVE_FERR_EN
  assign ferr              = ferr_q;
`endif
endmodule

// File: tb/tb_receive.sv
// Scoreboard bench for the UART receiver: frames push expected bytes, a monitor pops on each new byte.
module tb_receive;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       receive_baud;
  logic       rxd = 1'b1;
  logic       receive_read_en = 1'b0;
  logic [7:0] receive_read_line;
  logic       rda;
`ifdef RECEIVE_FERR_EN
  logic       ferr;
`endif

  receive #(.OVERSAMPLE(16)) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .receive_baud      (receive_baud),
    .rxd               (rxd),
    .receive_read_en   (receive_read_en),
    .receive_read_line (receive_read_line),
`ifdef RECEIVE_FERR_EN
    .ferr              (ferr),
`endif
    .rda               (rda)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  assign receive_baud = (cyc[1:0] == 2'd3);

  typedef struct { logic [7:0] d; logic f; } exp_t;
  exp_t q[$];

  int checks = 0;
  int errors = 0;
  int cyc0 = 0;
  int first_rda = -1;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", name, got, exp);
    end
  endtask

  // Scoreboard monitor: a new byte is either an rda rise or a data change while rda is held.
  initial begin
    logic       rda_p;
    logic [7:0] line_p;
    exp_t       e;
    rda_p = 1'b0;
    line_p = 8'h00;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        rda_p = 1'b0;
        line_p = 8'h00;
      end else begin
        if ((rda && !rda_p) || (rda && receive_read_line != line_p)) begin
          if (first_rda < 0) first_rda = cyc;
          if (q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_byte got=%0h expected=none", receive_read_line);
          end else begin
            e = q.pop_front();
            chk("rx_byte", {24'h0, receive_read_line}, {24'h0, e.d});
`ifdef RECEIVE_FERR_EN
            chk("rx_ferr", {31'h0, ferr}, {31'h0, e.f});
`endif
          end
        end
        rda_p = rda;
        line_p = receive_read_line;
      end
    end
  end

  // Align so the FSM's first START cycle coincides with a baud edge, then drop rxd.
  task automatic align_start();
    do begin
      @(posedge clk);
      #1;
    end while (cyc[1:0] != 2'd1);
    rxd = 1'b0;
    cyc0 = cyc;
  endtask

  task automatic hold_bit();
    repeat (64) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stopb);
    align_start();
    hold_bit();
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      hold_bit();
    end
    rxd = stopb;
    hold_bit();
    rxd = 1'b1;
    repeat (16) @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] d, input logic f);
    exp_t e;
    e.d = d;
    e.f = f;
    q.push_back(e);
  endtask

  task automatic read_pulse();
    @(posedge clk);
    #1 receive_read_en = 1'b1;
    @(posedge clk);
    #1 receive_read_en = 1'b0;
  endtask

  initial begin
    #1;
    chk("reset_rda", {31'h0, rda}, 32'h0);
    chk("reset_data", {24'h0, receive_read_line}, 32'h0);
`ifdef RECEIVE_FERR_EN
    chk("reset_ferr", {31'h0, ferr}, 32'h0);
`endif
    repeat (4) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (8) @(posedge clk);
    #1;

    // Clean frame plus edge-to-rda latency
    push(8'hA5, 1'b0);
    send_frame(8'hA5, 1'b1);
    chk("latency", first_rda - cyc0, 32'd611);
    chk("rda_after_A5", {31'h0, rda}, 32'h1);
    read_pulse();

    // Glitch: low for 3 baud ticks only
    align_start();
    repeat (12) @(posedge clk);
    #1 rxd = 1'b1;
    repeat (80) @(posedge clk);
    #1;
    chk("glitch_rda", {31'h0, rda}, 32'h0);
    push(8'h3C, 1'b0);
    send_frame(8'h3C, 1'b1);
    read_pulse();

    // Read handshake
    push(8'h5A, 1'b0);
    send_frame(8'h5A, 1'b1);
    read_pulse();
    chk("read_rda_clr", {31'h0, rda}, 32'h0);
    chk("read_data_keep", {24'h0, receive_read_line}, 32'h5A);

    // Overrun: 11 left unread, 22 overwrites
    push(8'h11, 1'b0);
    send_frame(8'h11, 1'b1);
    push(8'h22, 1'b0);
    send_frame(8'h22, 1'b1);
    chk("overrun_rda", {31'h0, rda}, 32'h1);
    chk("overrun_data", {24'h0, receive_read_line}, 32'h22);

    // Read collides with completion of 33
    push(8'h33, 1'b0);
    fork
      send_frame(8'h33, 1'b1);
      begin
        @(posedge clk);
        while (rxd !== 1'b0) @(posedge clk);
        repeat (609) @(posedge clk);
        #1 receive_read_en = 1'b1;
        @(posedge clk);
        #1 receive_read_en = 1'b0;
        @(negedge clk);
        chk("collide_rda", {31'h0, rda}, 32'h1);
        chk("collide_data", {24'h0, receive_read_line}, 32'h33);
      end
    join

    // Reset during data bit 4 with a byte still held
    align_start();
    hold_bit();
    for (int i = 0; i < 4; i++) begin
      rxd = i[0];
      hold_bit();
    end
    rxd = 1'b1;
    repeat (32) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midreset_rda", {31'h0, rda}, 32'h0);
    chk("midreset_data", {24'h0, receive_read_line}, 32'h0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (100) @(posedge clk);
    #1;
    push(8'hC3, 1'b0);
    send_frame(8'hC3, 1'b1);
    read_pulse();

`ifdef RECEIVE_FERR_EN
    push(8'hFF, 1'b1);
    send_frame(8'hFF, 1'b0);
    chk("ferr_rda", {31'h0, rda}, 32'h1);
    read_pulse();
    chk("ferr_clr", {31'h0, ferr}, 32'h0);
    push(8'h00, 1'b0);
    send_frame(8'h00, 1'b1);
    chk("good_rda", {31'h0, rda}, 32'h1);
    read_pulse();
`endif

    repeat (10) @(posedge clk);
    #1;
    chk("queue_drained", q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
